// File: rtl/da_control_pkg.sv
// Shared widths, FSM encoding and plane-tag format for the distributed-arithmetic FIR sequencer.
package da_control_pkg;
    localparam int DW    = 16;
    localparam int CW    = 20;
    localparam int AW    = 11;
    localparam int ACCW  = 39;
    localparam int LAT   = 3;
    localparam int PW    = 23;            // significant ACC_OUT bits: sum of 8 unsigned CW-bit words
    localparam int YW    = PW + DW + 1;
    localparam int NTAP  = 64;
    localparam int NBANK = 8;
    localparam int BW    = $clog2(DW);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_OUT   = 3'd4
    } state_e;

    typedef struct packed {
        logic          vld;
        logic [BW-1:0] bit_idx;
    } tag_t;
endpackage

// File: rtl/da_control_bitacc.sv
// Tracks issued bit-planes through the LAT-cycle DA pipe and shift-accumulates ACC_OUT into y.
// Output acc_next is the value the accumulator takes at the next edge; no backpressure.
module da_control_bitacc
    import da_control_pkg::*;
(
    input  logic          clk,
    input  logic          resetn,
    input  logic          clr,
    input  logic          issue_vld,
    input  logic [BW-1:0] issue_bit,
    input  logic [PW-1:0] plane_sum,
    output logic          done,
    output logic [YW-1:0] acc_next
);
    tag_t [LAT-1:0] tag_q;
    tag_t [LAT-1:0] tag_d;
    tag_t           tag_in;
    tag_t           tail;
    logic [YW-1:0]  acc_q;
    logic [YW-1:0]  acc_d;
    logic [YW-1:0]  term;

    assign tail = tag_q[LAT-1];

    always_comb begin
        tag_in         = '0;
        tag_in.vld     = issue_vld;
        tag_in.bit_idx = issue_bit;
        tag_d          = {tag_q[LAT-2:0], tag_in};
    end

    // The MSB plane of a two's-complement sample carries negative weight.
    always_comb begin
        term  = {{(YW-PW){1'b0}}, plane_sum} << tail.bit_idx;
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (tail.vld) begin
            if (tail.bit_idx == BW'(DW-1)) begin
                acc_d = acc_q - term;
            end else begin
                acc_d = acc_q + term;
            end
        end
    end

    assign done     = tail.vld && (tail.bit_idx == BW'(DW-1));
    assign acc_next = acc_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tag_q <= '0;
            acc_q <= '0;
        end else begin
            tag_q <= tag_d;
            acc_q <= acc_d;
        end
    end
endmodule

// File: rtl/da_control.sv
// Sequencer for the DA FIR: LUT loading, 64-tap delay line, bit-plane issue, output hold.
// Sample accept to out_valid is DW+LAT+1 cycles; out_data holds until out_ready, blocking new work.
module da_control
    import da_control_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [AW-1:0]   cfg_addr,
    input  logic [CW-1:0]   cfg_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [YW-1:0]   out_data,
    output logic [7:0]      da_a0,
    output logic [7:0]      da_a1,
    output logic [7:0]      da_a2,
    output logic [7:0]      da_a3,
    output logic [7:0]      da_a4,
    output logic [7:0]      da_a5,
    output logic [7:0]      da_a6,
    output logic [7:0]      da_a7,
    output logic [CW-1:0]   da_cin,
    output logic [AW-1:0]   da_caddr,
    output logic            da_wen,
    output logic            da_cen,
    output logic            da_clr,
    input  logic [ACCW-1:0] da_acc
);
    state_e                    state_q, state_d;
    logic [BW-1:0]             b_q, b_d;
    logic [NTAP-1:0][DW-1:0]   dl_q, dl_d;
    logic [NTAP-1:0]           plane;
    logic [NBANK*8-1:0]        da_a_q, da_a_d;
    logic                      cfg_ready_q, cfg_ready_d;
    logic                      in_ready_q, in_ready_d;
    logic                      out_valid_q, out_valid_d;
    logic [YW-1:0]             out_data_q, out_data_d;
    logic [CW-1:0]             da_cin_q, da_cin_d;
    logic [AW-1:0]             da_caddr_q, da_caddr_d;
    logic                      da_wen_q, da_wen_d;
    logic                      da_cen_q, da_cen_d;
    logic                      da_clr_q, da_clr_d;
    logic                      cfg_take;
    logic                      in_take;
    logic                      acc_done;
    logic [YW-1:0]             acc_next;
    logic                      unused_acc_hi;

    assign unused_acc_hi = ^da_acc[ACCW-1:PW];

    // A pending LUT write always wins over a sample in the same cycle.
    assign cfg_take = (state_q == ST_IDLE) && cfg_ready_q && cfg_valid;
    assign in_take  = (state_q == ST_IDLE) && in_ready_q && in_valid && !cfg_valid;

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cfg_take) begin
                    state_d = ST_WRITE;
                end else if (in_take) begin
                    state_d = ST_ISSUE;
                    b_d     = '0;
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_ISSUE: begin
                b_d = b_q + 1'b1;
                if (b_q == BW'(DW-1)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: if (acc_done) state_d = ST_OUT;
            ST_OUT:   if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        dl_d = dl_q;
        if (in_take) begin
            dl_d = {dl_q[NTAP-2:0], in_data};
        end
        plane = '0;
        for (int i = 0; i < NTAP; i++) begin
            plane[i] = dl_d[i][b_d];
        end
    end

    always_comb begin
        cfg_ready_d = (state_d == ST_IDLE);
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_OUT);
        da_cen_d    = !(state_d inside {ST_WRITE, ST_ISSUE, ST_DRAIN});
        da_wen_d    = (state_d != ST_WRITE);
        da_clr_d    = !(state_d inside {ST_ISSUE, ST_DRAIN});
        da_a_d      = (state_d == ST_ISSUE) ? plane : '0;
        da_caddr_d  = cfg_take ? cfg_addr : da_caddr_q;
        da_cin_d    = cfg_take ? cfg_data : da_cin_q;
        out_data_d  = acc_done ? acc_next : out_data_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            b_q         <= '0;
            dl_q        <= '0;
            da_a_q      <= '0;
            cfg_ready_q <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            da_cin_q    <= '0;
            da_caddr_q  <= '0;
            da_wen_q    <= 1'b1;
            da_cen_q    <= 1'b1;
            da_clr_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            b_q         <= b_d;
            dl_q        <= dl_d;
            da_a_q      <= da_a_d;
            cfg_ready_q <= cfg_ready_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            da_cin_q    <= da_cin_d;
            da_caddr_q  <= da_caddr_d;
            da_wen_q    <= da_wen_d;
            da_cen_q    <= da_cen_d;
            da_clr_q    <= da_clr_d;
        end
    end

    // da_a_q carries plane b_q while in ISSUE, so the tag enters alongside it.
    da_control_bitacc u_bitacc (
        .clk       (clk),
        .resetn    (resetn),
        .clr       (in_take),
        .issue_vld (state_q == ST_ISSUE),
        .issue_bit (b_q),
        .plane_sum (da_acc[PW-1:0]),
        .done      (acc_done),
        .acc_next  (acc_next)
    );

    assign cfg_ready = cfg_ready_q;
    assign in_ready  = in_ready_q && !cfg_valid;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign da_cin    = da_cin_q;
    assign da_caddr  = da_caddr_q;
    assign da_wen    = da_wen_q;
    assign da_cen    = da_cen_q;
    assign da_clr    = da_clr_q;
    assign da_a0     = da_a_q[7:0];
    assign da_a1     = da_a_q[15:8];
    assign da_a2     = da_a_q[23:16];
    assign da_a3     = da_a_q[31:24];
    assign da_a4     = da_a_q[39:32];
    assign da_a5     = da_a_q[47:40];
    assign da_a6     = da_a_q[55:48];
    assign da_a7     = da_a_q[63:56];
endmodule

// File: tb/tb_da_control.sv
// Directed bench for da_control with a behavioural 8-bank LUT SRAM + DA adder pipe (3 cycles).
module tb_da_control;
    logic        clk = 1'b0;
    logic        resetn;
    logic        cfg_valid, cfg_ready;
    logic [10:0] cfg_addr;
    logic [19:0] cfg_data;
    logic        in_valid, in_ready;
    logic [15:0] in_data;
    logic        out_valid, out_ready;
    logic [39:0] out_data;
    logic [7:0]  da_a0, da_a1, da_a2, da_a3, da_a4, da_a5, da_a6, da_a7;
    logic [19:0] da_cin;
    logic [10:0] da_caddr;
    logic        da_wen, da_cen, da_clr;
    logic [38:0] acc_r;

    logic [7:0][7:0]  a_vec;
    logic [19:0]      mem [8][256];
    logic [7:0][19:0] q;
    logic [22:0]      z, zsum;

    int n_cmp = 0;
    int n_bad = 0;

    da_control dut (
        .clk(clk), .resetn(resetn),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .da_a0(da_a0), .da_a1(da_a1), .da_a2(da_a2), .da_a3(da_a3),
        .da_a4(da_a4), .da_a5(da_a5), .da_a6(da_a6), .da_a7(da_a7),
        .da_cin(da_cin), .da_caddr(da_caddr), .da_wen(da_wen), .da_cen(da_cen),
        .da_clr(da_clr), .da_acc(acc_r)
    );

    always #5 clk = ~clk;

    assign a_vec = {da_a7, da_a6, da_a5, da_a4, da_a3, da_a2, da_a1, da_a0};

    always_comb begin
        zsum = '0;
        for (int k = 0; k < 8; k++) zsum = zsum + 23'(q[k]);
    end

    // SRAM Q register, adder Z register, ACC_OUT register
    initial begin
        for (int k = 0; k < 8; k++)
            for (int e = 0; e < 256; e++) mem[k][e] = '0;
        q = '0; z = '0; acc_r = '0;
        forever begin
            @(posedge clk);
            if (!da_cen && !da_wen) mem[da_caddr[10:8]][da_caddr[7:0]] <= da_cin;
            if (!da_cen && da_wen)
                for (int k = 0; k < 8; k++) q[k] <= mem[k][a_vec[k]];
            z     <= zsum;
            acc_r <= da_clr ? 39'd0 : {16'd0, z};
        end
    end

    task automatic lut_write(input logic [10:0] addr, input logic [19:0] data);
        int n = 0;
        cfg_addr = addr; cfg_data = data; cfg_valid = 1'b1;
        #1;
        while (cfg_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // Returns at the negedge where out_valid is first seen; lat counts cycles from accept.
    task automatic send_sample(input logic [15:0] x, output logic [39:0] y, output int lat);
        int n = 0;
        in_data = x; in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
        y = out_data;
    endtask

    task automatic test_reset();
        cfg_valid = 0; in_valid = 0; out_ready = 1; cfg_addr = '0; cfg_data = '0; in_data = '0;
        resetn = 1'b1;
        #2 resetn = 1'b0;
        #20;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL rst_cfg_ready: got %b want 0", cfg_ready); end
        n_cmp++; if ({da_cen, da_wen, da_clr} !== 3'b111) begin n_bad++; $display("FAIL rst_cen_wen_clr: got %b want 111", {da_cen, da_wen, da_clr}); end
        n_cmp++; if (a_vec !== 64'h0) begin n_bad++; $display("FAIL rst_da_a: got %h want 0", a_vec); end
        n_cmp++; if (out_data !== 40'h0) begin n_bad++; $display("FAIL rst_out_data: got %h want 0", out_data); end
        @(negedge clk) resetn = 1'b1;
        @(negedge clk);
        n_cmp++; if ({cfg_ready, in_ready, da_cen, da_wen, da_clr} !== 5'b11111) begin
            n_bad++; $display("FAIL idle_outputs: got %b want 11111", {cfg_ready, in_ready, da_cen, da_wen, da_clr}); end
    endtask

    task automatic test_write();
        cfg_addr = 11'h001; cfg_data = 20'h00001; cfg_valid = 1'b1;
        #1;
        n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL wr_ready: got %b want 1", cfg_ready); end
        @(negedge clk);
        cfg_valid = 1'b0;
        n_cmp++; if ({da_cen, da_wen} !== 2'b00) begin n_bad++; $display("FAIL wr_strobe: got cen/wen %b want 00", {da_cen, da_wen}); end
        n_cmp++; if (da_caddr !== 11'h001) begin n_bad++; $display("FAIL wr_caddr: got %h want 001", da_caddr); end
        n_cmp++; if (da_cin !== 20'h00001) begin n_bad++; $display("FAIL wr_cin: got %h want 00001", da_cin); end
        n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL wr_busy: got cfg_ready %b want 0", cfg_ready); end
        @(negedge clk);
        n_cmp++; if ({da_cen, da_wen, cfg_ready} !== 3'b111) begin n_bad++; $display("FAIL wr_one_cycle: got cen/wen/rdy %b want 111", {da_cen, da_wen, cfg_ready}); end
    endtask

    task automatic test_sample5();
        logic [39:0] y; int lat;
        // h0=1: every odd bank-0 entry holds 1 (entry 1 already written)
        for (int e = 3; e < 256; e += 2) lut_write(11'(e), 20'd1);
        send_sample(16'd5, y, lat);
        n_cmp++; if (y !== 40'd5) begin n_bad++; $display("FAIL s5_data: got %0d want 5", $signed(y)); end
        n_cmp++; if (lat !== 20) begin n_bad++; $display("FAIL s5_latency: got %0d want 20", lat); end
        @(negedge clk);
        n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_bad++; $display("FAIL s5_release: got valid/ready %b want 01", {out_valid, in_ready}); end
    endtask

    task automatic test_negative();
        logic [39:0] y; int lat;
        send_sample(16'h8000, y, lat);
        n_cmp++; if (y !== 40'(-32768)) begin n_bad++; $display("FAIL neg_data: got %0d want -32768", $signed(y)); end
        n_cmp++; if (lat !== 20) begin n_bad++; $display("FAIL neg_latency: got %0d want 20", lat); end
        @(negedge clk);
    endtask

    task automatic test_priority();
        logic [39:0] y; int lat;
        cfg_addr = 11'h001; cfg_data = 20'd1; cfg_valid = 1'b1;
        in_data = 16'd7; in_valid = 1'b1;
        #1;
        n_cmp++; if ({cfg_ready, in_ready} !== 2'b10) begin n_bad++; $display("FAIL pri_first: got cfg/in ready %b want 10", {cfg_ready, in_ready}); end
        @(negedge clk);
        cfg_valid = 1'b0;
        n_cmp++; if ({da_wen, in_ready} !== 2'b00) begin n_bad++; $display("FAIL pri_write: got wen/in_ready %b want 00", {da_wen, in_ready}); end
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL pri_accept2: got in_ready %b want 1", in_ready); end
        send_sample(16'd7, y, lat);
        n_cmp++; if (y !== 40'd7) begin n_bad++; $display("FAIL pri_data: got %0d want 7", $signed(y)); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [39:0] y; int lat;
        out_ready = 1'b0;
        send_sample(16'd3, y, lat);
        n_cmp++; if (y !== 40'd3) begin n_bad++; $display("FAIL bp_data: got %0d want 3", $signed(y)); end
        n_cmp++; if (lat !== 20) begin n_bad++; $display("FAIL bp_latency: got %0d want 20", lat); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b1 || out_data !== 40'd3) begin
                n_bad++; $display("FAIL bp_hold[%0d]: got valid %b data %0d want 1 3", i, out_valid, $signed(out_data)); end
            n_cmp++; if ({in_ready, cfg_ready} !== 2'b00) begin
                n_bad++; $display("FAIL bp_ready[%0d]: got in/cfg %b want 00", i, {in_ready, cfg_ready}); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_bad++; $display("FAIL bp_release: got valid/ready %b want 01", {out_valid, in_ready}); end
    endtask

    task automatic test_reset_mid();
        in_data = 16'h1234; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++; if ({da_cen, da_clr} !== 2'b00) begin n_bad++; $display("FAIL mid_issuing: got cen/clr %b want 00", {da_cen, da_clr}); end
        resetn = 1'b0;
        #1;
        n_cmp++; if ({out_valid, in_ready, cfg_ready} !== 3'b000) begin
            n_bad++; $display("FAIL mid_rst_ready: got %b want 000", {out_valid, in_ready, cfg_ready}); end
        n_cmp++; if ({da_cen, da_wen, da_clr} !== 3'b111) begin n_bad++; $display("FAIL mid_rst_sram: got %b want 111", {da_cen, da_wen, da_clr}); end
        n_cmp++; if (a_vec !== 64'h0) begin n_bad++; $display("FAIL mid_rst_da_a: got %h want 0", a_vec); end
        n_cmp++; if (out_data !== 40'h0) begin n_bad++; $display("FAIL mid_rst_out_data: got %h want 0", out_data); end
        @(negedge clk) resetn = 1'b1;
        @(negedge clk);
        n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_recover: got cfg_ready %b want 1", cfg_ready); end
    endtask

    task automatic test_impulse();
        logic [39:0] y, exp_y; int lat;
        // h_k = k: bank k, single-bit entry j holds 8k+j
        for (int k = 0; k < 8; k++)
            for (int j = 0; j < 8; j++)
                lut_write({3'(k), 8'(1 << j)}, 20'(8*k + j));
        for (int n = 0; n <= 64; n++) begin
            send_sample((n == 0) ? 16'd1 : 16'd0, y, lat);
            exp_y = (n < 64) ? 40'(n) : 40'd0;
            n_cmp++; if (y !== exp_y || lat !== 20) begin
                n_bad++; $display("FAIL impulse[%0d]: got %0d lat %0d want %0d lat 20", n, $signed(y), lat, $signed(exp_y)); end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_sample5();
        test_negative();
        test_priority();
        test_backpressure();
        test_reset_mid();
        test_impulse();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
